prog_loader: RTL and testbench

- Byte-stream program loader; the writer end of the CPU's instruction-memory read path.
- Accepts a framed program image over a valid/ready byte interface and writes it into instruction memory.
- Holds the CPU in reset while loading and releases it once the last write has committed.
- Sits between the host/debug link and the cpu instruction RAM write port.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared between the program loader and the CPU: instruction
// memory geometry, the frame start marker and the loader state encoding.
package cpu_pkg;

  localparam int          IMEM_ADDR_W = 4;
  localparam int          IMEM_DATA_W = 8;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DRAIN,
    ST_RUN
  } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC, LEN, data[, checksum] frames into
// instruction-memory writes. Define LOADER_CHECKSUM_EN to add the checksum stage.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter int         DATA_W    = IMEM_DATA_W,
  parameter logic [7:0] SYNC_BYTE = cpu_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so a full-depth frame length (2**ADDR_W) is representable.
  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  loader_state_e     state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  len_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic xfer;
  logic len_ok;
  logic last_byte;

  assign xfer      = in_valid && in_ready;
  assign len_ok    = (in_data != 8'd0) && (int'(in_data) <= DEPTH);
  assign last_byte = (count_q + CNT_W'(1)) == len_q;

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // reads the pre-edge values; blocking here would make later reads see new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      len_q      <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      imem_we  <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (xfer && in_data == SYNC_BYTE) begin
            state_q  <= ST_LEN;
            err      <= 1'b0;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (xfer) begin
            if (len_ok) begin
              len_q   <= CNT_W'(in_data);
              count_q <= '0;
              state_q <= ST_DATA;
            end else begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= count_q[ADDR_W-1:0];
            imem_wdata <= DATA_W'(in_data);
            count_q    <= count_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_q + in_data;
            if (last_byte) state_q <= ST_CHK;
`else
            if (last_byte) begin
              state_q  <= ST_DRAIN;
              in_ready <= 1'b0;
            end
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            if (in_data == sum_q) begin
              state_q  <= ST_DRAIN;
              in_ready <= 1'b0;
            end else begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
`endif
        ST_DRAIN: begin
          // The final write is committing this cycle; release the CPU after it.
          state_q  <= ST_RUN;
          cpu_hold <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them and tracks done/cpu_hold timing.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       imem_we;
  logic [3:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
  localparam int HOLD_LAT = 2;
`else
  localparam int HOLD_LAT = 1;
`endif

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int last_we_cyc = 0;
  int hold_fall_cyc = 0;
  logic hold_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: plays the role of the instruction RAM and checks every write.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!reset) begin
      if (done) done_cnt++;
      if (hold_prev && !cpu_hold) hold_fall_cyc = cyc;
      if (imem_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        check("hold_during_write", cpu_hold, 1);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", imem_addr, e.addr);
          check("wr_data", imem_wdata, e.data);
        end
        mem[imem_addr] = imem_wdata;
      end
    end
    hold_prev = cpu_hold;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", n < 20, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic wait_release();
    int n = 0;
    while (cpu_hold && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("release_timeout", n < 60, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int d0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(2);

    // Frame A: three bytes
    d0 = done_cnt;
    expect_wr(4'd0, 8'h11); expect_wr(4'd1, 8'h22); expect_wr(4'd2, 8'h33);
    send_byte(8'hA5);
    check("busy_in_frame", busy, 1);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h66);
`endif
    wait_release();
    check("A_done_once", done_cnt - d0, 1);
    check("A_hold_lat", hold_fall_cyc - last_we_cyc, HOLD_LAT);
    check("A_mem0", mem[0], 8'h11);
    check("A_mem1", mem[1], 8'h22);
    check("A_mem2", mem[2], 8'h33);
    check("A_mem3_untouched", mem[3], 8'hEE);
    check("A_queue_empty", exp_q.size(), 0);
    check("A_busy_idle", busy, 0);

    // Length errors: zero and oversize
    d0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    idle_cycles(2);
    check("L0_err", err, 1);
    check("L0_hold", cpu_hold, 1);
    check("L0_no_write", we_cnt - d0, 0);
    send_byte(8'hA5);
    check("err_cleared_on_sync", err, 0);
    send_byte(8'h11);
    idle_cycles(2);
    check("L17_err", err, 1);
    check("L17_hold", cpu_hold, 1);
    check("L17_no_write", we_cnt - d0, 0);
    expect_wr(4'd0, 8'hAA); expect_wr(4'd1, 8'hBB);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h65);
`endif
    wait_release();
    check("recover_err", err, 0);
    check("recover_queue_empty", exp_q.size(), 0);

    // Full-depth frame, back-to-back bytes
    d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      expect_wr(4'(i), 8'(i));
      send_byte(8'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h78);
`endif
    wait_release();
    check("F_done_once", done_cnt - d0, 1);
    check("F_mem15", mem[15], 8'h0F);
    check("F_mem0", mem[0], 8'h00);
    check("F_queue_empty", exp_q.size(), 0);

    // Garbage before sync is dropped
    d0 = we_cnt;
    expect_wr(4'd0, 8'h7E);
    send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h7E);
`endif
    wait_release();
    check("G_single_write", we_cnt - d0, 1);
    check("G_mem0", mem[0], 8'h7E);

    // Re-sync while running: CPU re-held before any write
    check("R_running", cpu_hold, 0);
    d0 = we_cnt;
    expect_wr(4'd0, 8'hFF);
    send_byte(8'hA5);
    check("R_hold_after_sync", cpu_hold, 1);
    check("R_no_write_yet", we_cnt - d0, 0);
    send_byte(8'h01); send_byte(8'hFF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    wait_release();
    check("R_released", cpu_hold, 0);
    check("R_mem0", mem[0], 8'hFF);

    // Reset mid-DATA after 2 of 4 bytes; second write is cancelled
    expect_wr(4'd0, 8'h01);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    #2;
    reset = 1'b1;
    #1;
    check("MR_imem_we", imem_we, 0);
    check("MR_cpu_hold", cpu_hold, 1);
    check("MR_in_ready", in_ready, 0);
    check("MR_busy", busy, 0);
    check("MR_addr", imem_addr, 0);
    idle_cycles(2);
    reset = 1'b0;
    check("MR_queue_empty", exp_q.size(), 0);
    idle_cycles(1);
    expect_wr(4'd0, 8'hC3); expect_wr(4'd1, 8'h3C);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    wait_release();
    check("MR_fresh_mem0", mem[0], 8'hC3);
    check("MR_fresh_mem1", mem[1], 8'h3C);
    check("MR_fresh_queue", exp_q.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: data stays written, CPU stays held
    expect_wr(4'd0, 8'h05);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    idle_cycles(3);
    check("CK_err", err, 1);
    check("CK_hold", cpu_hold, 1);
    check("CK_mem0", mem[0], 8'h05);
`endif

    idle_cycles(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
